// File: rtl/str_fifo.sv
// rtl/str_fifo.sv - first-word-fall-through stream FIFO with fill-level status
module str_fifo #(
   parameter int DW    = 8,
   parameter int AW    = 4,
   parameter int AFULL = 12
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] idata,
   input  logic          ivalid,
   output logic          iready,
   output logic [DW-1:0] odata,
   output logic          ovalid,
   input  logic          oready,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty,
   output logic          almost_full
);

   localparam int DEPTH = 1 << AW;

   generate
      if (AW < 1 || AW > 12) begin : g_bad_aw
         $error("str_fifo: AW must be in 1..12");
      end
      if (AFULL < 1 || AFULL > DEPTH) begin : g_bad_afull
         $error("str_fifo: AFULL must be in 1..DEPTH");
      end
   endgenerate

   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
   localparam logic [AW:0] AFULL_W = (AW+1)'(AFULL);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;
   logic [AW:0]   cnt;
   logic          ish;
   logic          osh;

   // Every status flag comes straight from the registered count, so iready
   // never looks at ivalid and ovalid never looks at oready.
   assign full        = (cnt == DEPTH_W);
   assign empty       = (cnt == '0);
   assign almost_full = (cnt >= AFULL_W);
   assign count       = cnt;
   assign iready      = ~full;
   assign ovalid      = ~empty;
   assign ish         = ivalid & iready;
   assign osh         = ovalid & oready;

   // Head word is read from storage; forced to zero while empty so reset
   // presents a clean output without having to clear the array.
   assign odata = empty ? '0 : mem[rp];

   // Storage write; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (!rst && ish) begin
         mem[wp] <= idata;
      end
   end

   // Pointers wrap by natural AW-bit overflow; count tracks net occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (ish) begin
            wp <= wp + 1'b1;
         end
         if (osh) begin
            rp <= rp + 1'b1;
         end
         case ({ish, osh})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_str_fifo.sv
// tb/tb_str_fifo.sv - directed vector table plus random-stall scoreboard for str_fifo
module tb_str_fifo;

   localparam int DW    = 8;
   localparam int AW    = 2;
   localparam int AFULL = 3;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] idata;
   logic          ivalid;
   logic          iready;
   logic [DW-1:0] odata;
   logic          ovalid;
   logic          oready;
   logic [AW:0]   count;
   logic          full;
   logic          empty;
   logic          almost_full;

   int checks = 0;
   int errors = 0;

   str_fifo #(.DW(DW), .AW(AW), .AFULL(AFULL)) dut (
      .clk(clk),
      .rst(rst),
      .idata(idata),
      .ivalid(ivalid),
      .iready(iready),
      .odata(odata),
      .ovalid(ovalid),
      .oready(oready),
      .count(count),
      .full(full),
      .empty(empty),
      .almost_full(almost_full)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       iv;
      logic [7:0] id;
      logic       ordy;
      int         e_count;
      logic [7:0] e_odata;
      logic       chk_od;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic iv, input logic [7:0] id, input logic ordy,
                      input int ec, input logic [7:0] eod, input logic cod);
      vec_t v;
      v.rst = r; v.iv = iv; v.id = id; v.ordy = ordy;
      v.e_count = ec; v.e_odata = eod; v.chk_od = cod;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_status(input string tag, input int ec);
      chk({tag, " count"}, 32'(count), 32'(ec));
      chk({tag, " empty"}, 32'(empty), 32'(ec == 0));
      chk({tag, " ovalid"}, 32'(ovalid), 32'(ec != 0));
      chk({tag, " full"}, 32'(full), 32'(ec == DEPTH));
      chk({tag, " iready"}, 32'(iready), 32'(ec != DEPTH));
      chk({tag, " almost_full"}, 32'(almost_full), 32'(ec >= AFULL));
   endtask

   logic [7:0] q[$];
   int         mcount;
   int         rd_words;
   int         cyc;
   logic       m_ish, m_osh, prev_hold;
   logic [7:0] prev_od;

   initial begin
      rst = 1'b1; ivalid = 1'b0; idata = '0; oready = 1'b0;

      // reset, fill to full, refused write, drain
      add(1, 0, 8'h00, 0, 0, 8'h00, 1);
      add(1, 0, 8'h00, 0, 0, 8'h00, 1);
      add(0, 1, 8'h11, 0, 1, 8'h11, 1);
      add(0, 1, 8'h22, 0, 2, 8'h11, 1);
      add(0, 1, 8'h33, 0, 3, 8'h11, 1);
      add(0, 1, 8'h44, 0, 4, 8'h11, 1);
      add(0, 1, 8'h55, 0, 4, 8'h11, 1);
      add(0, 0, 8'h00, 1, 3, 8'h22, 1);
      add(0, 0, 8'h00, 1, 2, 8'h33, 1);
      add(0, 0, 8'h00, 1, 1, 8'h44, 1);
      add(0, 0, 8'h00, 1, 0, 8'h00, 0);
      // simultaneous read/write at count 2, wraps pointers
      add(0, 1, 8'ha0, 0, 1, 8'ha0, 1);
      add(0, 1, 8'ha1, 0, 2, 8'ha0, 1);
      add(0, 1, 8'ha2, 1, 2, 8'ha1, 1);
      add(0, 1, 8'ha3, 1, 2, 8'ha2, 1);
      add(0, 1, 8'ha4, 1, 2, 8'ha3, 1);
      add(0, 1, 8'ha5, 1, 2, 8'ha4, 1);
      add(0, 1, 8'ha6, 1, 2, 8'ha5, 1);
      add(0, 1, 8'ha7, 1, 2, 8'ha6, 1);
      // full with read and write offered together
      add(0, 1, 8'hb0, 0, 3, 8'ha6, 1);
      add(0, 1, 8'hb1, 0, 4, 8'ha6, 1);
      add(0, 1, 8'hb2, 1, 3, 8'ha7, 1);
      add(0, 1, 8'hb2, 0, 4, 8'ha7, 1);
      add(0, 0, 8'h00, 1, 3, 8'hb0, 1);
      add(0, 0, 8'h00, 1, 2, 8'hb1, 1);
      add(0, 0, 8'h00, 1, 1, 8'hb2, 1);
      add(0, 0, 8'h00, 1, 0, 8'h00, 0);
      // reset mid-operation discards contents
      add(0, 1, 8'hc0, 0, 1, 8'hc0, 1);
      add(0, 1, 8'hc1, 0, 2, 8'hc0, 1);
      add(1, 1, 8'hc2, 0, 0, 8'h00, 1);
      add(0, 1, 8'hd0, 0, 1, 8'hd0, 1);

      for (int i = 0; i < vecs.size(); i++) begin
         rst = vecs[i].rst; ivalid = vecs[i].iv; idata = vecs[i].id; oready = vecs[i].ordy;
         @(posedge clk);
         #1;
         chk_status($sformatf("vec%0d", i), vecs[i].e_count);
         if (vecs[i].chk_od) begin
            chk($sformatf("vec%0d odata", i), 32'(odata), 32'(vecs[i].e_odata));
         end
      end

      // hand sequence: a held word stays put while stalled
      rst = 1'b0; ivalid = 1'b1; idata = 8'h5a; oready = 1'b0;
      @(posedge clk); #1;
      ivalid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk("stall head", 32'(odata), 32'h000000d0);
         chk("stall count", 32'(count), 32'd2);
      end

      // random stall stress against a queue scoreboard
      rst = 1'b1; ivalid = 1'b0; oready = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      q.delete();
      mcount = 0; rd_words = 0; cyc = 0; prev_hold = 1'b0; prev_od = '0;
      while (rd_words < 1000 && cyc < 20000) begin
         ivalid = 1'($urandom_range(0, 1));
         oready = 1'($urandom_range(0, 1));
         idata  = 8'($urandom_range(0, 255));
         rst    = (cyc == 1200);
         if (prev_hold) begin
            chk("hold ovalid", 32'(ovalid), 32'd1);
            chk("hold odata", 32'(odata), 32'(prev_od));
         end
         m_ish = ivalid && (mcount < DEPTH);
         m_osh = oready && (mcount > 0);
         if (m_osh && !rst) begin
            chk($sformatf("sb word %0d", rd_words), 32'(odata), 32'(q[0]));
         end
         prev_hold = ovalid && !oready && !rst;
         prev_od   = odata;
         @(posedge clk); #1;
         if (rst) begin
            q.delete();
            mcount = 0;
            chk("mid reset count", 32'(count), 32'd0);
            chk("mid reset empty", 32'(empty), 32'd1);
         end else begin
            if (m_osh) begin
               void'(q.pop_front());
               rd_words++;
            end
            if (m_ish) begin
               q.push_back(idata);
            end
            mcount = q.size();
            chk("stress count", 32'(count), 32'(mcount));
            chk("stress iready", 32'(iready), 32'(mcount != DEPTH));
            chk("stress ovalid", 32'(ovalid), 32'(mcount != 0));
         end
         cyc++;
      end
      rst = 1'b0;
      chk("stress completed within budget", 32'(rd_words >= 1000), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
